// File: rtl/tdpsram_banked_if.sv
// Request/response bus for both ports of the banked true-dual-port SRAM.
interface tdpsram_banked_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DATA_DEPTH = 1024,
    parameter int unsigned BYTE_SIZE  = 8
);
    localparam int unsigned ADDR_W = $clog2(DATA_DEPTH);
    localparam int unsigned BE_W   = DATA_WIDTH / BYTE_SIZE;

    // Port 0
    logic                  en0_i;
    logic                  ready0_o;
    logic [ADDR_W-1:0]     addr0_i;
    logic [BE_W-1:0]       we0_i;
    logic [DATA_WIDTH-1:0] wdata0_i;
    logic                  rvalid0_o;
    logic [DATA_WIDTH-1:0] rdata0_o;

    // Port 1
    logic                  en1_i;
    logic                  ready1_o;
    logic [ADDR_W-1:0]     addr1_i;
    logic [BE_W-1:0]       we1_i;
    logic [DATA_WIDTH-1:0] wdata1_i;
    logic                  rvalid1_o;
    logic [DATA_WIDTH-1:0] rdata1_o;

    modport master (
        output en0_i, addr0_i, we0_i, wdata0_i,
        output en1_i, addr1_i, we1_i, wdata1_i,
        input  ready0_o, rvalid0_o, rdata0_o,
        input  ready1_o, rvalid1_o, rdata1_o
    );

    modport slave (
        input  en0_i, addr0_i, we0_i, wdata0_i,
        input  en1_i, addr1_i, we1_i, wdata1_i,
        output ready0_o, rvalid0_o, rdata0_o,
        output ready1_o, rvalid1_o, rdata1_o
    );
endinterface

// File: rtl/tdpsram_banked.sv
// Banked true-dual-port SRAM: low address bits pick the bank, same-bank
// collisions are arbitrated, responses are write-first with 1 or 2 cycles latency.
module tdpsram_banked #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DATA_DEPTH   = 1024,
    parameter int unsigned BYTE_SIZE    = 8,
    parameter int unsigned BANK_NUM     = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter string       ARB_MODE     = "rr"
) (
    input  logic                   clk,
    input  logic                   rst,
    tdpsram_banked_if.slave        bus,
    output logic [31:0]            conflict_cnt_o
);
    localparam int unsigned BE_W      = DATA_WIDTH / BYTE_SIZE;
    localparam int unsigned BANK_BITS = $clog2(BANK_NUM);
    localparam int unsigned BANK_W    = (BANK_BITS == 0) ? 1 : BANK_BITS;
    localparam int unsigned ROWS      = DATA_DEPTH / BANK_NUM;
    localparam int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam bit          ARB_P1    = (ARB_MODE == "p1");

    // Reject illegal configurations at elaboration
    if (BANK_NUM < 1 || BANK_NUM > 16 || (BANK_NUM & (BANK_NUM - 1)) != 0) begin : g_bad_bank
        $fatal(1, "tdpsram_banked: BANK_NUM must be a power of two in 1..16");
    end
    if ((DATA_DEPTH & (DATA_DEPTH - 1)) != 0 || (DATA_DEPTH % BANK_NUM) != 0) begin : g_bad_depth
        $fatal(1, "tdpsram_banked: DATA_DEPTH must be a power of two divisible by BANK_NUM");
    end
    if (BYTE_SIZE == 0 || (DATA_WIDTH % BYTE_SIZE) != 0) begin : g_bad_byte
        $fatal(1, "tdpsram_banked: DATA_WIDTH must be divisible by BYTE_SIZE");
    end
    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
        $fatal(1, "tdpsram_banked: READ_LATENCY must be 1 or 2");
    end
    if (ARB_MODE != "rr" && ARB_MODE != "p1") begin : g_bad_arb
        $fatal(1, "tdpsram_banked: ARB_MODE must be \"rr\" or \"p1\"");
    end

    logic [DATA_WIDTH-1:0] r_mem [BANK_NUM][ROWS];

    logic [BANK_W-1:0]     w_bank0, w_bank1;
    logic [ROW_W-1:0]      w_row0, w_row1;
    logic                  w_collision, w_p0_loses, w_p1_loses;
    logic                  w_grant0, w_grant1;
    logic [DATA_WIDTH-1:0] w_old0, w_old1, w_resp0, w_resp1;

    logic                  r_prio;   // 1 favours port 1 on the next collision
    logic [31:0]           r_conflict_cnt;
    logic                  r_v1_0, r_v1_1;
    logic [DATA_WIDTH-1:0] r_d1_0, r_d1_1;

    // Bank select from the low address bits; a single bank has no select field
    if (BANK_BITS == 0) begin : g_one_bank
        assign w_bank0 = '0;
        assign w_bank1 = '0;
    end else begin : g_multi_bank
        assign w_bank0 = bus.addr0_i[BANK_W-1:0];
        assign w_bank1 = bus.addr1_i[BANK_W-1:0];
    end
    assign w_row0 = ROW_W'(bus.addr0_i >> BANK_BITS);
    assign w_row1 = ROW_W'(bus.addr1_i >> BANK_BITS);

    // Same-bank collision detection and grant decision in the request cycle
    always_comb begin
        w_collision = bus.en0_i && bus.en1_i && (w_bank0 == w_bank1);
        w_p0_loses  = w_collision && (ARB_P1 || r_prio);
        w_p1_loses  = w_collision && !(ARB_P1 || r_prio);
        w_grant0    = !rst && bus.en0_i && !w_p0_loses;
        w_grant1    = !rst && bus.en1_i && !w_p1_loses;
    end

    assign bus.ready0_o = w_grant0;
    assign bus.ready1_o = w_grant1;

    // Write-first response: written bytes take new data, others the stored word
    always_comb begin
        w_old0  = r_mem[w_bank0][w_row0];
        w_old1  = r_mem[w_bank1][w_row1];
        w_resp0 = w_old0;
        w_resp1 = w_old1;
        for (int i = 0; i < BE_W; i++) begin
            if (bus.we0_i[i]) w_resp0[i*BYTE_SIZE +: BYTE_SIZE] = bus.wdata0_i[i*BYTE_SIZE +: BYTE_SIZE];
            if (bus.we1_i[i]) w_resp1[i*BYTE_SIZE +: BYTE_SIZE] = bus.wdata1_i[i*BYTE_SIZE +: BYTE_SIZE];
        end
    end

    // Byte-enabled bank writes; grants never target the same bank twice
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (w_grant0 && bus.we0_i[i])
                r_mem[w_bank0][w_row0][i*BYTE_SIZE +: BYTE_SIZE] <= bus.wdata0_i[i*BYTE_SIZE +: BYTE_SIZE];
            if (w_grant1 && bus.we1_i[i])
                r_mem[w_bank1][w_row1][i*BYTE_SIZE +: BYTE_SIZE] <= bus.wdata1_i[i*BYTE_SIZE +: BYTE_SIZE];
        end
    end

    // Round-robin pointer flips to the loser; conflict counter saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio         <= 1'b0;
            r_conflict_cnt <= '0;
        end else if (w_collision) begin
            if (!ARB_P1) r_prio <= !r_prio;
            if (r_conflict_cnt != 32'hFFFF_FFFF) r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign conflict_cnt_o = r_conflict_cnt;

    // First response stage; data holds between grants
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1_0 <= 1'b0;
            r_v1_1 <= 1'b0;
            r_d1_0 <= '0;
            r_d1_1 <= '0;
        end else begin
            r_v1_0 <= w_grant0;
            r_v1_1 <= w_grant1;
            if (w_grant0) r_d1_0 <= w_resp0;
            if (w_grant1) r_d1_1 <= w_resp1;
        end
    end

    if (READ_LATENCY == 2) begin : g_lat2
        logic                  r_v2_0, r_v2_1;
        logic [DATA_WIDTH-1:0] r_d2_0, r_d2_1;

        // Optional output register stage, always advancing
        always_ff @(posedge clk) begin
            if (rst) begin
                r_v2_0 <= 1'b0;
                r_v2_1 <= 1'b0;
                r_d2_0 <= '0;
                r_d2_1 <= '0;
            end else begin
                r_v2_0 <= r_v1_0;
                r_v2_1 <= r_v1_1;
                if (r_v1_0) r_d2_0 <= r_d1_0;
                if (r_v1_1) r_d2_1 <= r_d1_1;
            end
        end

        assign bus.rvalid0_o = r_v2_0;
        assign bus.rdata0_o  = r_d2_0;
        assign bus.rvalid1_o = r_v2_1;
        assign bus.rdata1_o  = r_d2_1;
    end else begin : g_lat1
        assign bus.rvalid0_o = r_v1_0;
        assign bus.rdata0_o  = r_d1_0;
        assign bus.rvalid1_o = r_v1_1;
        assign bus.rdata1_o  = r_d1_1;
    end
endmodule

// File: tb/tb_tdpsram_banked.sv
// Scoreboard bench for tdpsram_banked: two instances (rr/latency 1 and
// p1/latency 2) driven in lockstep and checked against a word-level model.
module tb_tdpsram_banked;
    typedef struct packed {
        logic        en;
        logic [9:0]  addr;
        logic [3:0]  we;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  mask;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   cyc = 0;
    logic rst_seen = 1'b1;
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    req_t        cur [2][2];
    logic        rdy [2][2];
    logic        rv  [2][2];
    logic [31:0] rd  [2][2];
    logic [31:0] cnt [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        tdpsram_banked_if #(.DATA_WIDTH(32), .DATA_DEPTH(1024), .BYTE_SIZE(8)) bus ();

        assign bus.en0_i    = cur[g][0].en;
        assign bus.addr0_i  = cur[g][0].addr;
        assign bus.we0_i    = cur[g][0].we;
        assign bus.wdata0_i = cur[g][0].wdata;
        assign bus.en1_i    = cur[g][1].en;
        assign bus.addr1_i  = cur[g][1].addr;
        assign bus.we1_i    = cur[g][1].we;
        assign bus.wdata1_i = cur[g][1].wdata;
        assign rdy[g][0] = bus.ready0_o;
        assign rdy[g][1] = bus.ready1_o;
        assign rv[g][0]  = bus.rvalid0_o;
        assign rv[g][1]  = bus.rvalid1_o;
        assign rd[g][0]  = bus.rdata0_o;
        assign rd[g][1]  = bus.rdata1_o;

        if (g == 0) begin : g_rr
            tdpsram_banked #(
                .DATA_WIDTH(32), .DATA_DEPTH(1024), .BYTE_SIZE(8), .BANK_NUM(4),
                .READ_LATENCY(1), .ARB_MODE("rr")
            ) u_dut (
                .clk(clk), .rst(rst), .bus(bus), .conflict_cnt_o(cnt[0])
            );
        end else begin : g_p1
            tdpsram_banked #(
                .DATA_WIDTH(32), .DATA_DEPTH(1024), .BYTE_SIZE(8), .BANK_NUM(4),
                .READ_LATENCY(2), .ARB_MODE("p1")
            ) u_dut (
                .clk(clk), .rst(rst), .bus(bus), .conflict_cnt_o(cnt[1])
            );
        end
    end

    // Reference state: memory words with known-byte masks, arbitration
    // preference, conflict count, and per-(instance,port) expected responses.
    logic [31:0] mmem   [2][1024];
    logic [3:0]  mknown [2][1024];
    logic        mprio  [2];
    logic [31:0] mcnt   [2];
    exp_t        sbq    [4][$];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic logic [31:0] bytemask(input logic [3:0] m);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = m[b] ? 8'hFF : 8'h00;
        return r;
    endfunction

    function automatic req_t rq(input int addr, input logic [3:0] we, input logic [31:0] wdata);
        req_t r;
        r.en    = 1'b1;
        r.addr  = 10'(addr);
        r.we    = we;
        r.wdata = wdata;
        return r;
    endfunction

    // One clock: predict grants for the held requests, record expected
    // responses, then offer new requests to ports that are free.
    task automatic step(input req_t n0, input req_t n1, input logic rst_next);
        logic      coll, win1;
        logic      grd [2][2];
        int        a;
        exp_t      e;
        exp_t      keep [$];
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("conflict_cnt d%0d", d), 64'(cnt[d]), 64'(mcnt[d]));
            coll = cur[d][0].en && cur[d][1].en && ((cur[d][0].addr % 4) == (cur[d][1].addr % 4));
            win1 = (d == 1) ? 1'b1 : mprio[d];
            for (int p = 0; p < 2; p++) begin
                grd[d][p] = !rst && cur[d][p].en && !(coll && (win1 == (p == 0)));
                chk($sformatf("ready d%0d p%0d", d, p), 64'(rdy[d][p]), 64'(grd[d][p]));
                if (grd[d][p]) begin
                    a = int'(cur[d][p].addr);
                    for (int b = 0; b < 4; b++) begin
                        if (cur[d][p].we[b]) begin
                            mmem[d][a][b*8 +: 8] = cur[d][p].wdata[b*8 +: 8];
                            mknown[d][a][b] = 1'b1;
                        end
                    end
                    e.data = mmem[d][a];
                    e.mask = mknown[d][a];
                    e.due  = cyc + lat(d);
                    sbq[d*2+p].push_back(e);
                end
            end
            if (rst) begin
                mprio[d] = 1'b0;
                mcnt[d]  = '0;
                for (int p = 0; p < 2; p++) begin
                    keep.delete();
                    foreach (sbq[d*2+p][k]) if (sbq[d*2+p][k].due <= cyc) keep.push_back(sbq[d*2+p][k]);
                    sbq[d*2+p] = keep;
                end
            end else if (coll) begin
                if (mcnt[d] != 32'hFFFF_FFFF) mcnt[d] = mcnt[d] + 32'd1;
                if (d == 0) mprio[d] = !mprio[d];
            end
        end
        @(posedge clk);
        #1;
        rst = rst_next;
        for (int d = 0; d < 2; d++) begin
            if (grd[d][0] || !cur[d][0].en) cur[d][0] = n0;
            if (grd[d][1] || !cur[d][1].en) cur[d][1] = n1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0);
    endtask

    // Monitor: pop and compare on every rvalid; check data hold otherwise
    initial begin
        logic [31:0] last [2][2];
        exp_t        e;
        int          qi;
        for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) last[d][p] = '0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < 2; p++) begin
                    qi = d*2 + p;
                    if (rst_seen) last[d][p] = '0;
                    if (rv[d][p]) begin
                        chk($sformatf("rvalid_has_request d%0d p%0d", d, p),
                            64'(rv[d][p]), 64'(sbq[qi].size() > 0));
                        if (sbq[qi].size() > 0) begin
                            e = sbq[qi].pop_front();
                            chk($sformatf("latency d%0d p%0d", d, p), 64'(cyc), 64'(e.due));
                            chk($sformatf("rdata d%0d p%0d", d, p),
                                64'(rd[d][p] & bytemask(e.mask)), 64'(e.data & bytemask(e.mask)));
                        end
                        last[d][p] = rd[d][p];
                    end else begin
                        chk($sformatf("rdata_hold d%0d p%0d", d, p), 64'(rd[d][p]), 64'(last[d][p]));
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin
        req_t n0, n1;
        for (int d = 0; d < 2; d++) begin
            mprio[d] = 1'b0;
            mcnt[d]  = '0;
            for (int p = 0; p < 2; p++) cur[d][p] = '0;
            for (int a = 0; a < 1024; a++) begin
                mmem[d][a]   = '0;
                mknown[d][a] = '0;
            end
        end
        repeat (3) @(negedge clk);
        step('0, '0, 1'b0);

        // Preload words 0..63, two banks in parallel per cycle
        for (int k = 0; k < 32; k++) step(rq(2*k, 4'hF, $urandom), rq(2*k+1, 4'hF, $urandom), 1'b0);

        // Bank-parallel writes then reads
        step(rq(4, 4'hF, 32'hDEADBEEF), rq(5, 4'hF, 32'h12345678), 1'b0);
        step(rq(4, 4'h0, 32'h0), rq(5, 4'h0, 32'h0), 1'b0);
        idle(4);
        chk("cnt_parallel d0", 64'(cnt[0]), 64'd0);
        chk("cnt_parallel d1", 64'(cnt[1]), 64'd0);

        // Byte-enable write-first
        step('0, rq(8, 4'hF, 32'hAABBCCDD), 1'b0);
        step('0, rq(8, 4'b0101, 32'h11223344), 1'b0);
        step('0, rq(8, 4'h0, 32'h0), 1'b0);
        idle(4);

        // Three collision cycles on bank 0
        for (int k = 0; k < 3; k++) step(rq(0, 4'h0, 32'h0), rq(4, 4'h0, 32'h0), 1'b0);
        idle(4);
        chk("cnt_rr3 d0", 64'(cnt[0]), 64'd3);
        chk("cnt_rr3 d1", 64'(cnt[1]), 64'd3);

        // Same address: port 0 reads, port 1 writes 5
        step(rq(12, 4'h0, 32'h0), rq(12, 4'hF, 32'h5), 1'b0);
        idle(5);

        // Back-to-back read stream on port 0
        for (int a = 0; a < 8; a++) step(rq(a, 4'h0, 32'h0), '0, 1'b0);
        idle(5);

        // Random traffic over a small window to provoke collisions
        for (int k = 0; k < 1500; k++) begin
            n0 = rq($urandom_range(0, 63), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, $urandom);
            n1 = rq($urandom_range(0, 63), ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, $urandom);
            n0.en = ($urandom_range(0, 9) < 7);
            n1.en = ($urandom_range(0, 9) < 7);
            step(n0, n1, 1'b0);
        end
        idle(5);

        // Reset one cycle after a read grant
        step(rq(3, 4'h0, 32'h0), '0, 1'b0);
        step('0, '0, 1'b1);
        step('0, '0, 1'b0);
        idle(4);
        chk("cnt_after_reset d0", 64'(cnt[0]), 64'd0);
        chk("cnt_after_reset d1", 64'(cnt[1]), 64'd0);

        // Preference restarts at port 0 after reset
        step(rq(0, 4'h0, 32'h0), rq(4, 4'h0, 32'h0), 1'b0);
        idle(6);

        for (int i = 0; i < 4; i++) chk($sformatf("drained q%0d", i), 64'(sbq[i].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
